// File: rtl/fhg_tx_pkt_fifo_if.sv
// AXI-Stream bundle for the TX packet FIFO.
// master drives data/valid, slave drives ready.
interface fhg_tx_pkt_fifo_if #(
    parameter int DATA_WIDTH = 1024
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tuser;
    logic                    tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/fhg_tx_pkt_fifo.sv
// Store-and-forward TX packet buffer: only complete, good packets
// are released; bad or overflowing packets are dropped whole.
module fhg_tx_pkt_fifo #(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fhg_tx_pkt_fifo_if.slave      s_axis,
    fhg_tx_pkt_fifo_if.master     m_axis,
    output logic [AW:0]           stat_pkt_cnt,
    output logic [31:0]           stat_drop_cnt,
    output logic                  stat_drop
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int MW = DATA_WIDTH + KW + 1;
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_PKT,
        WR_DROP
    } wr_state_t;

    wr_state_t state;
    wr_state_t state_nxt;

    logic [AW:0] wr_ptr;
    logic [AW:0] wr_ptr_nxt;
    logic [AW:0] wr_start;
    logic [AW:0] wr_start_nxt;
    logic [AW:0] rd_ptr;
    logic [AW:0] fetch_ptr;

    logic in_rdy;
    logic beat;
    logic full;
    logic we;
    logic commit;
    logic drop_now;

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] mem_q;
    logic [MW-1:0] out_q;
    logic [MW-1:0] head;

    logic a_vld;
    logic b_vld;
    logic pop;
    logic a_keep;
    logic issue;
    logic b_load;
    logic head_last;

    assign s_axis.tready = in_rdy;
    assign beat = s_axis.tvalid && in_rdy;
    // full is judged on the pre-read rd_ptr, so a same-cycle read
    // never frees the slot for this cycle's write
    assign full = (wr_ptr - rd_ptr) == DEPTH_P;

    // write-side FSM: next state and pointer updates
    always_comb begin
        state_nxt    = state;
        wr_ptr_nxt   = wr_ptr;
        wr_start_nxt = wr_start;
        we           = 1'b0;
        commit       = 1'b0;
        drop_now     = 1'b0;
        unique case (state)
            WR_IDLE, WR_PKT: begin
                if (beat) begin
                    if (full) begin
                        wr_ptr_nxt = wr_start;
                        if (s_axis.tlast) begin
                            drop_now  = 1'b1;
                            state_nxt = WR_IDLE;
                        end else begin
                            state_nxt = WR_DROP;
                        end
                    end else if (s_axis.tlast && s_axis.tuser) begin
                        wr_ptr_nxt = wr_start;
                        drop_now   = 1'b1;
                        state_nxt  = WR_IDLE;
                    end else begin
                        we         = 1'b1;
                        wr_ptr_nxt = wr_ptr + ONE;
                        if (s_axis.tlast) begin
                            commit       = 1'b1;
                            wr_start_nxt = wr_ptr + ONE;
                            state_nxt    = WR_IDLE;
                        end else begin
                            state_nxt = WR_PKT;
                        end
                    end
                end
            end
            WR_DROP: begin
                if (beat && s_axis.tlast) begin
                    drop_now  = 1'b1;
                    state_nxt = WR_IDLE;
                end
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    // write-side state and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WR_IDLE;
            wr_ptr   <= '0;
            wr_start <= '0;
            in_rdy   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            wr_start <= wr_start_nxt;
            in_rdy   <= 1'b1;
        end
    end

    // buffer storage: {tlast, tkeep, tdata} per beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end

    // Two-entry FWFT read pipe: A is the memory read register,
    // B the output hold register; the head is B when full, else A.
    assign head      = b_vld ? out_q : mem_q;
    assign head_last = head[MW-1];
    assign pop       = m_axis.tvalid && m_axis.tready;
    assign a_keep    = a_vld && b_vld && !pop;
    assign issue     = (fetch_ptr != wr_start) && !a_keep;
    assign b_load    = a_vld && (b_vld ? pop : !pop);

    assign m_axis.tvalid = a_vld || b_vld;
    assign m_axis.tdata  = head[DATA_WIDTH-1:0];
    assign m_axis.tkeep  = head[DATA_WIDTH +: KW];
    assign m_axis.tlast  = head_last;
    assign m_axis.tuser  = 1'b0;

    // read pipeline: fetch only committed beats, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q     <= '0;
            out_q     <= '0;
            a_vld     <= 1'b0;
            b_vld     <= 1'b0;
            fetch_ptr <= '0;
            rd_ptr    <= '0;
        end else begin
            if (issue) begin
                mem_q     <= mem[fetch_ptr[AW-1:0]];
                fetch_ptr <= fetch_ptr + ONE;
            end
            a_vld <= issue || a_keep;
            if (b_load) begin
                out_q <= mem_q;
            end
            if (b_vld && pop) begin
                b_vld <= a_vld;
            end else if (!b_vld && a_vld && !pop) begin
                b_vld <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE;
            end
        end
    end

    // packet and drop statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkt_cnt  <= '0;
            stat_drop_cnt <= '0;
            stat_drop     <= 1'b0;
        end else begin
            if (commit && !(pop && head_last)) begin
                stat_pkt_cnt <= stat_pkt_cnt + ONE;
            end else if (!commit && pop && head_last) begin
                stat_pkt_cnt <= stat_pkt_cnt - ONE;
            end
            stat_drop <= drop_now;
            if (drop_now && stat_drop_cnt != 32'hFFFF_FFFF) begin
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_fhg_tx_pkt_fifo.sv
// Bench for fhg_tx_pkt_fifo: packet-level reference model feeding
// a scoreboard queue, independent output monitor.
module tb_fhg_tx_pkt_fifo;
    localparam int DW    = 1024;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fhg_tx_pkt_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    fhg_tx_pkt_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    logic [AW:0] pkt_cnt;
    logic [31:0] drop_cnt;
    logic        drop;

    fhg_tx_pkt_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .stat_pkt_cnt (pkt_cnt),
        .stat_drop_cnt(drop_cnt),
        .stat_drop    (drop)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state
    int occ, m_drops, m_pkts, m_commits, commit_cyc;
    bit dropping;
    // monitor state
    int beats_out, pulses, first_valid_cyc;
    bit mid;

    int rdy_pct = 100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint got, longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference model: buffer holds whole packets; a beat that finds
    // the buffer full kills its packet; bad tlast kills its packet.
    always @(negedge clk) begin : model
        beat_t b;
        if (!rst_n) begin
            exp_q.delete();
            cur.delete();
            occ       = 0;
            m_drops   = 0;
            m_pkts    = 0;
            m_commits = 0;
            dropping  = 0;
        end else begin
            if (s_if.tvalid && s_if.tready) begin
                b.d = s_if.tdata;
                b.k = s_if.tkeep;
                b.l = s_if.tlast;
                if (dropping) begin
                    if (s_if.tlast) begin
                        m_drops++;
                        dropping = 0;
                    end
                end else if (occ == DEPTH) begin
                    occ -= cur.size();
                    cur.delete();
                    if (s_if.tlast) m_drops++;
                    else dropping = 1;
                end else if (s_if.tlast && s_if.tuser) begin
                    occ -= cur.size();
                    cur.delete();
                    m_drops++;
                end else begin
                    cur.push_back(b);
                    occ++;
                    if (s_if.tlast) begin
                        foreach (cur[i]) exp_q.push_back(cur[i]);
                        cur.delete();
                        m_pkts++;
                        m_commits++;
                        commit_cyc = cyc;
                    end
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                occ--;
                if (m_if.tlast) m_pkts--;
            end
        end
    end

    // Output monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst_n) begin
            beats_out       = 0;
            pulses          = 0;
            mid             = 0;
            first_valid_cyc = -1;
        end else begin
            if (drop) pulses++;
            if (m_if.tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (mid) begin
                checks++;
                if (!m_if.tvalid) begin
                    errors++;
                    $display("FAIL gap: tvalid=0 inside packet at cycle %0d", cyc);
                end
            end
            if (m_if.tvalid && m_if.tready) begin
                beats_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: unexpected output d=%h at cycle %0d",
                             m_if.tdata[63:0], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (m_if.tdata !== e.d || m_if.tkeep !== e.k ||
                        m_if.tlast !== e.l || m_if.tuser !== 1'b0) begin
                        errors++;
                        $display("FAIL beat: got d=%h k=%h l=%b u=%b want d=%h k=%h l=%b u=0",
                                 m_if.tdata[63:0], m_if.tkeep[31:0], m_if.tlast,
                                 m_if.tuser, e.d[63:0], e.k[31:0], e.l);
                    end
                end
                mid = !m_if.tlast;
            end
        end
    end

    // downstream ready generator
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.tready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(int n);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pkt(int len, bit bad, int gap_pct, int stop_at, bit seq);
        bit acc;
        int tries;
        for (int i = 0; i < len && i < stop_at; i++) begin
            if ($urandom_range(99) < gap_pct) begin
                s_if.tvalid = 1'b0;
                s_if.tuser  = 1'($urandom);
                @(posedge clk);
                #1;
            end
            s_if.tvalid = 1'b1;
            s_if.tlast  = (i == len - 1);
            if (seq) begin
                s_if.tdata = DW'(i + 1);
                s_if.tkeep = '1;
                s_if.tuser = 1'b0;
            end else begin
                for (int w = 0; w < DW / 32; w++) s_if.tdata[w*32 +: 32] = $urandom;
                s_if.tkeep = (i == len - 1) ?
                             {$urandom, $urandom, $urandom, $urandom} : '1;
                s_if.tuser = (i == len - 1) ? bad : 1'($urandom);
            end
            if (s_if.tlast && seq) s_if.tuser = bad;
            tries = 0;
            do begin
                @(negedge clk);
                acc = s_if.tready;
                @(posedge clk);
                #1;
                tries++;
            end while (!acc && tries < 16);
            if (!acc) chk("tready_timeout", 0, 1);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic wait_drain(int max);
        int n = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        idle(4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(3);
        chk("rst_m_tvalid", m_if.tvalid, 0);
        chk("rst_s_tready", s_if.tready, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_drop", drop, 0);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        #1;

        // T1: single sequential packet, latency and order
        rdy_pct = 100;
        do_reset();
        send_pkt(64, 0, 0, 64, 1);
        wait_drain(400);
        chk("t1_latency", first_valid_cyc - commit_cyc, 2);
        chk("t1_beats", beats_out, 64);
        chk("t1_pkt_cnt", pkt_cnt, 0);

        // T2: bad packet dropped, next good one passes
        do_reset();
        send_pkt(64, 1, 0, 64, 0);
        idle(5);
        chk("t2_pulses", pulses, 1);
        chk("t2_drop_cnt", drop_cnt, 1);
        chk("t2_pkt_cnt", pkt_cnt, 0);
        chk("t2_no_out", beats_out, 0);
        send_pkt(64, 0, 0, 64, 0);
        wait_drain(400);
        chk("t2_beats", beats_out, 64);

        // T3: stalled output, fifth packet overflows
        rdy_pct = 0;
        do_reset();
        for (int p = 0; p < 5; p++) send_pkt(64, 0, 0, 64, 0);
        idle(4);
        chk("t3_pkt_cnt", pkt_cnt, 4);
        chk("t3_drop_cnt", drop_cnt, 1);
        chk("t3_no_out", beats_out, 0);
        rdy_pct = 100;
        wait_drain(1000);
        chk("t3_beats", beats_out, 256);
        chk("t3_pulses", pulses, 1);
        chk("t3_pkt_cnt_end", pkt_cnt, 0);

        // T4: oversize packet into an empty buffer
        do_reset();
        send_pkt(300, 0, 0, 300, 0);
        send_pkt(64, 0, 0, 64, 0);
        wait_drain(400);
        chk("t4_drop_cnt", drop_cnt, 1);
        chk("t4_beats", beats_out, 64);

        // T5: random gaps, random ready, occasional bad packets
        do_reset();
        rdy_pct = 80;
        for (int p = 0; p < 440; p++) begin
            send_pkt(64, ($urandom_range(15) == 0), 10, 64, 0);
        end
        rdy_pct = 100;
        wait_drain(2000);
        chk("t5_drop_cnt", drop_cnt, m_drops);
        chk("t5_pulses", pulses, m_drops);
        chk("t5_beats", beats_out, 64 * m_commits);
        chk("t5_pkt_cnt", pkt_cnt, 0);

        // T6: asynchronous reset with both sides mid-packet
        do_reset();
        send_pkt(64, 0, 0, 64, 0);
        send_pkt(64, 0, 0, 20, 0);
        chk("t6_pkt_cnt_pre", pkt_cnt, 1);
        chk("t6_streaming", m_if.tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_tvalid", m_if.tvalid, 0);
        chk("t6_async_tready", s_if.tready, 0);
        chk("t6_async_tdata", (m_if.tdata == '0), 1);
        chk("t6_async_pkt_cnt", pkt_cnt, 0);
        @(posedge clk);
        #1;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        chk("t6_pkt_cnt_post", pkt_cnt, 0);
        send_pkt(64, 0, 0, 64, 0);
        wait_drain(400);
        chk("t6_beats", beats_out, 64);
        chk("t6_drop_cnt", drop_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
